// File: rtl/tone_div_calc_pkg.sv
// Shared constants, FSM encoding and octave scaling for the tone divisor calculator.
package tone_div_calc_pkg;

   localparam int unsigned CLK_NUM = 100_000_000;
   localparam int unsigned SILENCE = 100_000_000;
   localparam int          DIV_W   = 22;
   localparam logic [DIV_W-1:0] DIV_MAX = 22'h3FFFFF;

   // Dividend is the clock rate; the divisor is a 32-bit tone doubled at most once.
   localparam int DVD_W = 27;
   localparam int DVS_W = 33;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CALC_L = 3'd2,
      CALC_R = 3'd3,
      COMMIT = 3'd4
   } state_t;

   // Octave 1 halves the tone, octave 3 doubles it into the extra bit, others pass through.
   function automatic logic [DVS_W-1:0] eff_div(input logic [31:0] f, input logic [2:0] oct);
      case (oct)
         3'd1:    return {1'b0, f} >> 1;
         3'd3:    return {f, 1'b0};
         default: return {1'b0, f};
      endcase
   endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle. On the start cycle the first
// step works straight from the port operands, so a full quotient takes exactly
// ITER cycles; quotient/done show the result of the step in progress.
module serial_divider import tone_div_calc_pkg::*; #(
   parameter int ITER = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVD_W-1:0] quotient,
   output logic             done
);

   localparam int CW = $clog2(ITER + 1);

   logic [DVS_W-1:0] rem, dvs, src_rem, src_dvs, rem_nx;
   logic [DVD_W-1:0] dq, src_dq, dq_nx;
   logic [CW-1:0]    cnt, remaining;
   logic [DVS_W:0]   rem_sh;
   logic             ge;

   // One restoring step: shift in the next dividend bit, subtract when it fits.
   always_comb begin
      src_rem   = start ? '0 : rem;
      src_dq    = start ? (dividend << (DVD_W - ITER)) : dq;
      src_dvs   = start ? divisor : dvs;
      remaining = start ? CW'(ITER) : cnt;
      rem_sh    = {src_rem, src_dq[DVD_W-1]};
      // A set top bit already exceeds any 33-bit divisor; the 33-bit difference is then exact.
      ge        = rem_sh[DVS_W] | (rem_sh[DVS_W-1:0] >= src_dvs);
      rem_nx    = ge ? (rem_sh[DVS_W-1:0] - src_dvs) : rem_sh[DVS_W-1:0];
      dq_nx     = {src_dq[DVD_W-2:0], ge};
   end

   assign quotient = dq_nx;
   assign done     = (remaining == CW'(1));

   // Iteration registers advance while a division is running.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem <= '0;
         dq  <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (start || cnt != '0) begin
         rem <= rem_nx;
         dq  <= dq_nx;
         dvs <= src_dvs;
         cnt <= remaining - CW'(1);
      end
   end

endmodule

// File: rtl/tone_div_calc.sv
// Turns raw left/right tone frequencies into note_gen divisors (CLK_NUM / f)
// with one shared serial divider, sequenced left then right, committed together.
module tone_div_calc import tone_div_calc_pkg::*; #(
   parameter int unsigned CLK_NUM = tone_div_calc_pkg::CLK_NUM,
   parameter int unsigned SILENCE = tone_div_calc_pkg::SILENCE,
   parameter int          ITER    = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      freqL,
   input  logic [31:0]      freqR,
   input  logic [2:0]       octave,
   output logic [DIV_W-1:0] note_div_left,
   output logic [DIV_W-1:0] note_div_right,
   output logic             div_valid,
   output logic             busy
);

   state_t           state, state_nx;
   logic             force_q, changed, kick, div_done;
   logic [31:0]      fl_s, fr_s;
   logic [2:0]       oct_s;
   logic [DVS_W-1:0] eff_l, eff_r, dvs_sel;
   logic [DVD_W-1:0] quo, q_left;

   // Silence wins over everything, then a zero divisor, then quotient overflow.
   function automatic logic [DIV_W-1:0] pick(input logic [31:0] raw,
                                             input logic [DVS_W-1:0] eff,
                                             input logic [DVD_W-1:0] q);
      if (raw == SILENCE)        return DIV_W'(1);
      else if (eff == '0)        return DIV_MAX;
      else if (|q[DVD_W-1:DIV_W]) return DIV_MAX;
      else                       return q[DIV_W-1:0];
   endfunction

   assign changed   = {freqL, freqR, octave} != {fl_s, fr_s, oct_s};
   assign dvs_sel   = (state == CALC_R) ? eff_r : eff_l;
   assign busy      = (state != IDLE);
   assign div_valid = (state == COMMIT);

   serial_divider #(.ITER(ITER)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (kick),
      .dividend (DVD_W'(CLK_NUM)),
      .divisor  (dvs_sel),
      .quotient (quo),
      .done     (div_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state: a changed tuple (or pending force) starts a full recompute.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (changed || force_q) state_nx = LOAD;
         LOAD:    state_nx = CALC_L;
         CALC_L:  if (div_done) state_nx = CALC_R;
         CALC_R:  if (div_done) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Shadow capture, divisor scaling, per-channel result latching and outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         force_q        <= 1'b1;
         fl_s           <= '0;
         fr_s           <= '0;
         oct_s          <= '0;
         eff_l          <= '0;
         eff_r          <= '0;
         q_left         <= '0;
         kick           <= 1'b0;
         note_div_left  <= DIV_W'(1);
         note_div_right <= DIV_W'(1);
      end else begin
         // Start the divider on the first cycle of each CALC phase.
         kick <= (state == LOAD) || (state == CALC_L && div_done);
         case (state)
            IDLE: if (changed || force_q) begin
               fl_s  <= freqL;
               fr_s  <= freqR;
               oct_s <= octave;
            end
            LOAD: begin
               force_q <= 1'b0;
               eff_l   <= eff_div(fl_s, oct_s);
               eff_r   <= eff_div(fr_s, oct_s);
            end
            CALC_L: if (div_done) q_left <= quo;
            CALC_R: if (div_done) begin
               note_div_left  <= pick(fl_s, eff_l, q_left);
               note_div_right <= pick(fr_s, eff_r, quo);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/tone_div_calc.md
TONE_DIV_CALC -- requirements
Module: tone_div_calc

Interface
REQ-001 SHALL have parameter CLK_NUM, default 100_000_000, meaning the dividend (system clock rate in Hz).
REQ-002 SHALL have parameter SILENCE, default 100_000_000, meaning the raw tone code that denotes a muted channel.
REQ-003 SHALL have parameter ITER, default 27, meaning the number of divider iterations per channel (CLK_NUM < 2^ITER).
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port freqL, input, 32, the raw left tone frequency from the music module.
REQ-007 SHALL have port freqR, input, 32, the raw right tone frequency.
REQ-008 SHALL have port octave, input, 3, the octave select (1 = down, 2 = unity, 3 = up, others = unity).
REQ-009 SHALL have port note_div_left, output, 22, the left divisor for note_gen.
REQ-010 SHALL have port note_div_right, output, 22, the right divisor for note_gen.
REQ-011 SHALL have port div_valid, output, 1, a one-cycle pulse on the cycle both divisors update.
REQ-012 SHALL have port busy, output, 1, high while a computation is in progress.

Function
REQ-013 SHALL replace the combinational 10^8 / f computation with a serial restoring divider that is shared by both channels.
REQ-014 SHALL implement the FSM states IDLE, LOAD, CALC_L, CALC_R and COMMIT.
REQ-015 SHALL, in IDLE, move to LOAD when {freqL, freqR, octave} differs from the last-sampled tuple or when the force flag is set; otherwise it SHALL stay in IDLE.
REQ-016 SHALL, in LOAD (1 cycle), capture the inputs into shadow registers, clear the force flag and compute the effective divisors at 33 bits: octave 1 gives f>>1, octave 3 gives f<<1 (no wrap), otherwise f.
REQ-017 SHALL spend exactly ITER cycles in CALC_L and then ITER cycles in CALC_R, producing one quotient bit per cycle.
REQ-018 SHALL, in COMMIT (1 cycle), update both outputs atomically, pulse div_valid and return to IDLE.
REQ-019 SHALL give a latency from the LOAD edge to the outputs updating of 2*ITER+1 cycles (55 with the defaults).
REQ-020 SHALL force the result for a channel to 22'd1 when its raw input equals SILENCE, regardless of octave.
REQ-021 SHALL force the result to 22'h3FFFFF when the effective divisor is 0 (for example f=0, or f=1 with octave 1).
REQ-022 SHALL saturate a quotient that is at least 2^22 to 22'h3FFFFF.
REQ-023 SHALL output floor(CLK_NUM / effective divisor) in all other cases.
REQ-024 SHALL NOT abort a computation when the inputs change while busy; the tuple check on return to IDLE SHALL start a new computation, so the latest inputs win.
REQ-025 SHALL drive busy high in LOAD, CALC_L, CALC_R and COMMIT, and low in IDLE.
REQ-026 SHALL hold both outputs at their previous values between COMMIT pulses.

Reset
REQ-027 SHALL, on rst low, immediately set note_div_left and note_div_right to 22'd1 (silence), div_valid and busy to 0, and the state to IDLE, and SHALL set the force flag to 1.
REQ-028 SHALL discard any partial result when reset occurs mid-operation, and SHALL recompute on the first cycle after rst is released.

Structure
REQ-029 SHALL place CLK_NUM, SILENCE, DIV_W=22, DIV_MAX=22'h3FFFFF and the state encodings in a shared constants package.
REQ-030 SHALL implement the iteration datapath in one sub-module, serial_divider, with ports start, dividend[26:0], divisor[32:0], quotient[26:0] and done, instantiated once.
REQ-031 SHALL keep the octave scaling, the silence/zero/saturation muxing and the FSM in tone_div_calc.

Verification
REQ-032 SHALL verify: rst released with freqL=440, freqR=440, octave=2 -> after 56 cycles, note_div_left=note_div_right=227272 and div_valid is pulsed once.
REQ-033 SHALL verify: freqL=440 with octave changed 2->3, then 3->1 -> results 113636, then 454545, with each update 55 cycles after its LOAD.
REQ-034 SHALL verify: freqR=100_000_000 with octave 1 and with octave 3 -> note_div_right=1 in both cases; freqL=0 -> 22'h3FFFFF; freqL=20 -> 22'h3FFFFF (saturated).
REQ-035 SHALL verify: freqL changed 440->523 at cycle 10 of CALC_L -> the first commit shows 227272, a second LOAD follows at once, and the final value is 191204.
REQ-036 SHALL verify: rst asserted during CALC_R -> outputs read 1 and busy reads 0 in the same cycle; after release, a full recompute occurs and the correct values appear.
